rtc_timekeeper: RTL and testbench
=================================

# rtc_timekeeper

Parametrised BCD time-of-day core for the clock project: divides the system clock down to a 1 Hz tick and keeps hours/minutes/seconds in BCD, internally always 24 h. Adds runtime 12/24 h display mode, in-place time setting and a latched alarm. It sits between the button/edge-detect front end and the 7-segment display multiplexer inside the top-level `tt_um_ender_clock`.

## Interface
- `CLK_DIV`, default 10_000_000: system clock cycles per second; legal for values ≥ 2. Prescaler width is `$clog2(CLK_DIV)`.
- `clk`  in  1  system clock, all state on the rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `ena`  in  1  when low, prescaler, time and alarm state are frozen and `inc` is ignored.
- `mode_12h`  in  1  display format select: 1 = 12 h, 0 = 24 h. Display-only; internal time is unaffected.
- `set_sel`  in  2  0 = run, 1 = set hours, 2 = set minutes, 3 = zero seconds.
- `inc`  in  1  single-cycle pulse, already debounced and edge-detected upstream.
- `alarm_en`  in  1  alarm arm.
- `alarm_hh`  in  8  alarm hour, BCD, 24 h.
- `alarm_mm`  in  8  alarm minute, BCD.
- `alarm_ack`  in  1  clears a latched alarm.
- `hh`  out  8  displayed hours, BCD, formatted per `mode_12h`.
- `mm`  out  8  minutes, BCD.
- `ss`  out  8  seconds, BCD.
- `pm`  out  1  1 when internal hour ≥ 12. Valid in both modes.
- `tick_1hz`  out  1  one-cycle pulse on each prescaler terminal count.
- `alarm`  out  1  latched alarm flag.

## Operation
- Reset:
  - Internal time 00:00:00 and prescaler = 0.
  - `alarm` = 0, `tick_1hz` = 0, `pm` = 0.
  - `hh` = 0x00 in 24 h mode, 0x12 in 12 h mode.
- Run mode (`set_sel` = 0, `ena` = 1):
  - Prescaler counts 0..CLK_DIV-1 and wraps.
  - `tick_1hz` is high during the cycle in which the count is CLK_DIV-1.
  - On that edge, seconds increment. Wrap and carry chain: 59→00 carries into minutes, 59→00 carries into hours, 23→00.
- Set modes (`set_sel` ≠ 0):
  - Prescaler held at 0, no `tick_1hz`, seconds frozen.
  - `set_sel` = 1: `inc` increments hours, wrapping 23→00, no carry.
  - `set_sel` = 2: `inc` increments minutes, wrapping 59→00, no carry into hours.
  - `set_sel` = 3: seconds forced to 00 every cycle; `inc` ignored.
  - Return to 0: prescaler restarts from 0, so the first tick arrives after CLK_DIV cycles.
  - `set_sel` changes mid-count: prescaler is cleared on the first set-mode cycle.
- 12 h formatting (combinational from registered state):
  - Internal 00 → 12 with `pm` = 0.
  - 01–11 → unchanged with `pm` = 0.
  - 12 → 12 with `pm` = 1.
  - 13–23 → internal − 12 with `pm` = 1.
  - `mm` and `ss` are unaffected by the mode.
- Alarm:
  - Sets only in run mode, on the tick edge where time advances to exactly `alarm_hh`:`alarm_mm`:00 with `alarm_en` = 1.
  - Latched until `alarm_ack` = 1 or `alarm_en` = 0, whichever comes first.
  - Set and ack on the same edge: set wins.
  - Setting the time manually to the alarm value never fires the alarm.
  - Non-BCD or out-of-range alarm inputs never match and raise no error.

## Timing
- Time registers, `alarm` and prescaler update on the clock edge. `hh`/`pm` formatting is combinational from registered state, no added latency.
- `inc` takes effect on the same edge it is sampled; time outputs change one cycle after `inc` is asserted.
- `tick_1hz` period is exactly CLK_DIV cycles in steady run mode.
- `ena` low freezes the prescaler value; it resumes from that value when `ena` returns high.
- `rst_n` asserted mid-count clears everything asynchronously; there is no tick on the release edge.

## Structure
- Shared package `clock_pkg`:
  - `set_sel_t` enum: RUN, SET_HH, SET_MM, ZERO_SS.
  - BCD constants for 59, 23 and 12.
  - Function `bcd_to_12h` returning hour and pm.
- Sub-module `bcd_mod_counter`:
  - Parameter MOD, 8-bit BCD value.
  - Inputs: `inc`, `clr`. Output: `carry`.
  - Instantiated for seconds (MOD = 60), minutes (MOD = 60) and hours (MOD = 24).
- Prescaler, set-mode muxing and alarm latch live in `rtc_timekeeper`.

## Test plan
All scenarios use CLK_DIV = 4.
- Reset with `mode_12h` = 1 → `hh` = 0x12, `mm` = 0x00, `ss` = 0x00, `pm` = 0, `alarm` = 0. First `tick_1hz` occurs on cycle 4 after release; `ss` = 0x01 the cycle after.
- Set time 23:59:59 via `set_sel`/`inc`, then run → after one tick, time 00:00:00. In 12 h mode `hh` = 0x12 with `pm` = 0; at 13:00, `hh` = 0x01 with `pm` = 1.
- `set_sel` = 2 at minute 59 with one `inc` → `mm` = 0x00 and `hh` unchanged. `set_sel` = 3 → `ss` = 0x00 and no `tick_1hz` while held.
- Alarm 07:30, time set to 07:29:59, `alarm_en` = 1 → `alarm` rises on the tick that gives 07:30:00 and holds. It clears on `alarm_ack`; with ack on the set edge, `alarm` = 1.
- `ena` = 0 for 10 cycles mid-count → no tick and no time change; the tick resumes at the same prescaler phase when `ena` returns high.
- Assert `rst_n` low mid-count at 12:34:56 → all outputs return to their reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and BCD helpers for the clock project's time-of-day core.
// Hours are kept internally in 24 h BCD; the 12 h view is derived combinationally.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HH  = 2'd1,
    SET_MM  = 2'd2,
    ZERO_SS = 2'd3
  } set_sel_t;

  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_23 = 8'h23;
  localparam logic [7:0] BCD_12 = 8'h12;

  typedef struct packed {
    logic [7:0] hour;
    logic       pm;
  } hour12_t;

  // Next value of a two-digit BCD counter whose final state is `last`.
  function automatic logic [7:0] bcd_next(input logic [7:0] val, input logic [7:0] last);
    if (val == last) return 8'h00;
    if (val[3:0] >= 4'd9) return {val[7:4] + 4'd1, 4'd0};
    return {val[7:4], val[3:0] + 4'd1};
  endfunction

  function automatic hour12_t bcd_to_12h(input logic [7:0] h24);
    hour12_t    r;
    logic [4:0] bin;
    logic [4:0] tens_rem;
    bin  = 5'(h24[7:4]) * 5'd10 + 5'(h24[3:0]);
    r.pm = (bin >= 5'd12);
    if (bin == 5'd0)       bin = 5'd12;
    else if (bin > 5'd12)  bin = bin - 5'd12;
    tens_rem = bin - 5'd10;
    if (bin >= 5'd10) r.hour = {4'd1, tens_rem[3:0]};
    else              r.hour = {4'd0, bin[3:0]};
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter with synchronous clear; carry marks the wrapping increment.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] value,
  output logic       carry
);

  localparam logic [7:0] LAST = 8'((((MOD - 1) / 10) * 16) + ((MOD - 1) % 10));

  logic [7:0] value_q;
  logic [7:0] value_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    value_d = value_q;
    if (clr)      value_d = 8'h00;
    else if (inc) value_d = bcd_next(value_q, LAST);
  end

  // NOTE: state flops use non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= 8'h00;
    else        value_q <= value_d;
  end

  assign value = value_q;
  assign carry = inc & ~clr & (value_q == LAST);

endmodule

// File: rtl/rtc_timekeeper.sv
// BCD time-of-day core: 1 Hz prescaler, hh:mm:ss carry chain, set modes,
// runtime 12/24 h display and a latched alarm.
module rtc_timekeeper
  import clock_pkg::*;
#(
  parameter int CLK_DIV = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       mode_12h,
  input  logic [1:0] set_sel,
  input  logic       inc,
  input  logic       alarm_en,
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  input  logic       alarm_ack,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
  output logic       tick_1hz,
  output logic       alarm
);

  localparam int            PW         = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  set_sel_t      mode;
  logic          run;
  logic          inc_eff;
  logic [PW-1:0] presc_q, presc_d;
  logic          alarm_q, alarm_d;
  logic          tick;

  logic [7:0] sec_val, min_val, hr_val;
  logic       sec_carry, min_carry, hr_carry;
  logic       min_inc, hr_inc, sec_clr;
  logic [7:0] min_next, hr_next;
  logic       alarm_hit;
  hour12_t    fmt;

  assign mode    = set_sel_t'(set_sel);
  assign run     = (mode == RUN);
  assign inc_eff = ena & inc;

  // Any set mode parks the prescaler at 0 so run mode restarts a full second.
  always_comb begin
    presc_d = presc_q;
    if (ena) begin
      if (!run)                     presc_d = '0;
      else if (presc_q == PRESC_LAST) presc_d = '0;
      else                          presc_d = presc_q + 1'b1;
    end
  end

  assign tick = ena & run & (presc_q == PRESC_LAST);

  // Carries only chain in run mode; manual edits never ripple into the next field.
  assign sec_clr = ena & (mode == ZERO_SS);
  assign min_inc = run ? sec_carry : ((mode == SET_MM) & inc_eff);
  assign hr_inc  = run ? min_carry : ((mode == SET_HH) & inc_eff);

  bcd_mod_counter #(.MOD(60)) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (tick),
    .clr   (sec_clr),
    .value (sec_val),
    .carry (sec_carry)
  );

  bcd_mod_counter #(.MOD(60)) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (min_inc),
    .clr   (1'b0),
    .value (min_val),
    .carry (min_carry)
  );

  bcd_mod_counter #(.MOD(24)) u_hr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hr_inc),
    .clr   (1'b0),
    .value (hr_val),
    .carry (hr_carry)
  );

  // Match against the time this tick produces; seconds wrapping implies :00.
  assign min_next  = bcd_next(min_val, BCD_59);
  assign hr_next   = min_carry ? bcd_next(hr_val, BCD_23) : hr_val;
  assign alarm_hit = sec_carry & alarm_en & (min_next == alarm_mm) & (hr_next == alarm_hh);

  always_comb begin
    alarm_d = alarm_q;
    if (ena) begin
      if (alarm_hit)                alarm_d = 1'b1;
      else if (alarm_ack || !alarm_en) alarm_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      alarm_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      alarm_q <= alarm_d;
    end
  end

  assign fmt      = bcd_to_12h(hr_val);
  assign hh       = mode_12h ? fmt.hour : hr_val;
  assign pm       = fmt.pm;
  assign mm       = min_val;
  assign ss       = sec_val;
  assign tick_1hz = tick;
  assign alarm    = alarm_q;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Directed bench for rtc_timekeeper with CLK_DIV = 4 and hand-computed expectations.
module tb_rtc_timekeeper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       mode_12h = 1'b0;
  logic [1:0] set_sel = 2'd0;
  logic       inc = 1'b0;
  logic       alarm_en = 1'b0;
  logic [7:0] alarm_hh = 8'h00;
  logic [7:0] alarm_mm = 8'h00;
  logic       alarm_ack = 1'b0;
  logic [7:0] hh, mm, ss;
  logic       pm, tick_1hz, alarm;

  int n_checks = 0;
  int n_fail   = 0;

  rtc_timekeeper #(.CLK_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .mode_12h  (mode_12h),
    .set_sel   (set_sel),
    .inc       (inc),
    .alarm_en  (alarm_en),
    .alarm_hh  (alarm_hh),
    .alarm_mm  (alarm_mm),
    .alarm_ack (alarm_ack),
    .hh        (hh),
    .mm        (mm),
    .ss        (ss),
    .pm        (pm),
    .tick_1hz  (tick_1hz),
    .alarm     (alarm)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_inc(input int n);
    for (int i = 0; i < n; i++) begin
      inc = 1'b1;
      step();
    end
    inc = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic expect_time(input string name, input logic [7:0] eh, input logic [7:0] em,
                             input logic [7:0] es);
    n_checks++;
    if ({hh, mm, ss} !== {eh, em, es}) begin
      n_fail++;
      $display("FAIL %s: got %h:%h:%h, want %h:%h:%h", name, hh, mm, ss, eh, em, es);
    end
  endtask

  task automatic test_reset();
    mode_12h = 1'b1;
    do_reset();
    expect_time("reset_time_12h", 8'h12, 8'h00, 8'h00);
    n_checks++;
    if ({pm, alarm, tick_1hz} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got pm/alarm/tick=%b, want 000", {pm, alarm, tick_1hz});
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      n_checks++;
      if (tick_1hz !== (i == 3)) begin
        n_fail++;
        $display("FAIL first_tick edge %0d: got %b, want %b", i, tick_1hz, (i == 3));
      end
    end
    step();
    expect_time("first_second", 8'h12, 8'h00, 8'h01);
    n_checks++;
    if (tick_1hz !== 1'b0) begin
      n_fail++;
      $display("FAIL tick_drop: got %b, want 0", tick_1hz);
    end
  endtask

  task automatic test_rollover();
    mode_12h = 1'b0;
    do_reset();
    set_sel = 2'd1; pulse_inc(23);
    set_sel = 2'd2; pulse_inc(59);
    set_sel = 2'd0;
    step(59 * 4);
    expect_time("set_235959", 8'h23, 8'h59, 8'h59);
    step(4);
    expect_time("midnight_24h", 8'h00, 8'h00, 8'h00);
    mode_12h = 1'b1;
    #1;
    n_checks++;
    if ({hh, pm} !== {8'h12, 1'b0}) begin
      n_fail++;
      $display("FAIL midnight_12h: got hh=%h pm=%b, want 12 0", hh, pm);
    end
    set_sel = 2'd1; pulse_inc(12);
    n_checks++;
    if ({hh, pm} !== {8'h12, 1'b1}) begin
      n_fail++;
      $display("FAIL noon_12h: got hh=%h pm=%b, want 12 1", hh, pm);
    end
    pulse_inc(1);
    n_checks++;
    if ({hh, pm} !== {8'h01, 1'b1}) begin
      n_fail++;
      $display("FAIL 13h_12h: got hh=%h pm=%b, want 01 1", hh, pm);
    end
    mode_12h = 1'b0;
    #1;
    n_checks++;
    if ({hh, pm} !== {8'h13, 1'b1}) begin
      n_fail++;
      $display("FAIL 13h_24h: got hh=%h pm=%b, want 13 1", hh, pm);
    end
  endtask

  task automatic test_set_fields();
    set_sel = 2'd2; pulse_inc(59);
    expect_time("set_mm_59", 8'h13, 8'h59, 8'h00);
    pulse_inc(1);
    expect_time("set_mm_wrap_no_carry", 8'h13, 8'h00, 8'h00);
    set_sel = 2'd0;
    step(20);
    expect_time("run_5s", 8'h13, 8'h00, 8'h05);
    set_sel = 2'd3;
    for (int i = 0; i < 12; i++) begin
      step();
      n_checks++;
      if ({ss, tick_1hz} !== {8'h00, 1'b0}) begin
        n_fail++;
        $display("FAIL zero_ss cycle %0d: got ss=%h tick=%b, want 00 0", i, ss, tick_1hz);
      end
    end
    expect_time("zero_ss_hold", 8'h13, 8'h00, 8'h00);
    set_sel = 2'd0;
  endtask

  task automatic test_alarm();
    mode_12h = 1'b0;
    do_reset();
    alarm_hh = 8'h07; alarm_mm = 8'h30; alarm_en = 1'b1;
    set_sel = 2'd1; pulse_inc(7);
    set_sel = 2'd2; pulse_inc(29);
    set_sel = 2'd0;
    step(59 * 4 + 3);
    expect_time("pre_alarm", 8'h07, 8'h29, 8'h59);
    n_checks++;
    if ({tick_1hz, alarm} !== 2'b10) begin
      n_fail++;
      $display("FAIL pre_alarm_flags: got tick/alarm=%b, want 10", {tick_1hz, alarm});
    end
    step();
    n_checks++;
    if ({hh, mm, ss, alarm} !== {8'h07, 8'h30, 8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL alarm_fire: got %h:%h:%h alarm=%b, want 07:30:00 1", hh, mm, ss, alarm);
    end
    step(4);
    n_checks++;
    if (alarm !== 1'b1) begin
      n_fail++;
      $display("FAIL alarm_hold: got %b, want 1", alarm);
    end
    alarm_ack = 1'b1; step(); alarm_ack = 1'b0;
    n_checks++;
    if (alarm !== 1'b0) begin
      n_fail++;
      $display("FAIL alarm_ack: got %b, want 0", alarm);
    end
    set_sel = 2'd2; pulse_inc(60);
    n_checks++;
    if ({mm, alarm} !== {8'h30, 1'b0}) begin
      n_fail++;
      $display("FAIL manual_set_no_alarm: got mm=%h alarm=%b, want 30 0", mm, alarm);
    end
    pulse_inc(59);
    set_sel = 2'd3; step();
    set_sel = 2'd0;
    step(59 * 4 + 3);
    alarm_ack = 1'b1;
    step();
    n_checks++;
    if (alarm !== 1'b1) begin
      n_fail++;
      $display("FAIL set_beats_ack: got %b, want 1", alarm);
    end
    step();
    alarm_ack = 1'b0;
    n_checks++;
    if (alarm !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_after_set: got %b, want 0", alarm);
    end
    alarm_en = 1'b0;
  endtask

  task automatic test_ena();
    do_reset();
    step(3);
    n_checks++;
    if (tick_1hz !== 1'b1) begin
      n_fail++;
      $display("FAIL ena_pre_tick: got %b, want 1", tick_1hz);
    end
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if ({tick_1hz, ss} !== {1'b0, 8'h00}) begin
        n_fail++;
        $display("FAIL ena_freeze cycle %0d: got tick=%b ss=%h, want 0 00", i, tick_1hz, ss);
      end
    end
    ena = 1'b1;
    #1;
    n_checks++;
    if (tick_1hz !== 1'b1) begin
      n_fail++;
      $display("FAIL ena_resume_phase: got %b, want 1", tick_1hz);
    end
    step();
    expect_time("ena_resume_second", 8'h00, 8'h00, 8'h01);
  endtask

  task automatic test_async_reset();
    mode_12h = 1'b1;
    do_reset();
    set_sel = 2'd1; pulse_inc(12);
    set_sel = 2'd2; pulse_inc(34);
    set_sel = 2'd0;
    step(56 * 4 + 2);
    expect_time("pre_reset_time", 8'h12, 8'h34, 8'h56);
    #2;
    rst_n = 1'b0;
    #1;
    expect_time("async_reset_time", 8'h12, 8'h00, 8'h00);
    n_checks++;
    if ({pm, tick_1hz, alarm} !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset_flags: got pm/tick/alarm=%b, want 000", {pm, tick_1hz, alarm});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    n_checks++;
    if ({tick_1hz, ss} !== {1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL post_reset_phase: got tick=%b ss=%h, want 0 00", tick_1hz, ss);
    end
    step();
    n_checks++;
    if (tick_1hz !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_tick: got %b, want 1", tick_1hz);
    end
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_set_fields();
    test_alarm();
    test_ena();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
